// File: rtl/spu_data_drain.sv
// Stream sink for cke-stalled spu_data pipelines: FWFT FIFO with registered upstream clock enable.
// Optional occupancy/peak reporting is enabled by defining SPU_DATA_DRAIN_LEVEL_EN.
module spu_data_drain #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         cke,
    input  logic                         s_valid,
    input  logic [DATA_BITS-1:0]         s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_BITS-1:0]         m_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [$clog2(DEPTH+1)-1:0]   peak_level
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic                 cke_r;
    logic                 m_valid_r;
    logic                 push_s;
    logic                 pop_s;
    logic [CW-1:0]        count_next_s;

    // Explicit wrap so non-power-of-two depths index only valid entries.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Transfer qualification and next occupancy.
    always_comb begin
        push_s       = cke_r & s_valid;
        pop_s        = m_valid_r & m_ready;
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and the registered cke/m_valid derived from next occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            cke_r     <= 1'b0;
            m_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r   <= count_next_s;
            cke_r     <= (count_next_s < FULL_CNT);
            m_valid_r <= (count_next_s != {CW{1'b0}});
        end
    end

    // Payload storage; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s_data;
        end
    end

    assign cke     = cke_r;
    assign m_valid = m_valid_r;
    assign m_data  = mem_r[rd_ptr_r];

`ifdef SPU_DATA_DRAIN_LEVEL_EN
    logic [CW-1:0] peak_r;

    // Sticky high-water mark, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_r <= {CW{1'b0}};
        end else if (count_next_s > peak_r) begin
            peak_r <= count_next_s;
        end else begin
            peak_r <= peak_r;
        end
    end

    assign level      = count_r;
    assign peak_level = peak_r;
`else
    assign level      = {CW{1'b0}};
    assign peak_level = {CW{1'b0}};
`endif

endmodule

// File: doc/spu_data_drain.md
# spu_data_drain

Stream sink for cke-stalled pipelines built from `spu_data` stages. Accepts the valid/data pair emerging from the last pipeline stage, buffers it in a small first-word-fall-through FIFO, and presents it downstream as a valid/ready stream. It generates the pipeline-wide `cke` from its own fill level, so downstream back-pressure stalls the whole upstream pipeline without any combinational path from `m_ready` to `cke`.

## Interface
- `DATA_BITS`, 8, payload width (≥1)
- `DEPTH`, 4, FIFO entries (≥2, need not be a power of two)
- `clk`  input  1  clock, all logic on rising edge
- `reset`  input  1  asynchronous, active-low reset (asserted when 0)
- `cke`  output  1  clock enable for the upstream pipeline; registered
- `s_valid`  input  1  valid bit travelling with the data through the upstream pipeline
- `s_data`  input  DATA_BITS  payload from the last upstream stage
- `m_valid`  output  1  FIFO head valid
- `m_ready`  input  1  downstream accept
- `m_data`  output  DATA_BITS  FIFO head payload
- `level`  output  $clog2(DEPTH+1)  current occupancy (see Configuration)
- `peak_level`  output  $clog2(DEPTH+1)  sticky maximum occupancy (see Configuration)

## Operation
- push = `cke & s_valid`; pop = `m_valid & m_ready`; `s_valid` and `s_data` are ignored while `cke`=0.
- Storage: DEPTH × DATA_BITS array, write pointer, read pointer, occupancy count 0..DEPTH.
- Pointers advance by 1 on push or pop respectively and wrap from DEPTH-1 to 0 explicitly.
- count_next = count + push − pop. Push and pop in the same cycle leave count unchanged; both pointers advance.
- `m_valid` = (count ≠ 0); `m_data` = mem[rd_ptr]. Head data is stable while `m_valid`=1 and `m_ready`=0.
- `cke` register next value = (count_next < DEPTH). Because `cke` is a register, no combinational path exists from `m_ready` or `s_valid` to `cke`.
- Overflow is impossible by construction. If count = DEPTH, then `cke`=0. A push with count = DEPTH is a design error; the bench asserts it never occurs.
- Pop with count = 0 cannot occur because `m_valid`=0.
- Reset (asynchronous, any time, including mid-transfer): count, pointers, `cke`, `level`, and `peak_level` all go to 0. `m_valid` goes to 0. Array contents are not reset.
- `m_data` is undefined while `m_valid`=0.

## Timing
- Reset values: `cke`=0, `m_valid`=0, `level`=0, `peak_level`=0.
- The first rising edge after reset release loads `cke`=1.
- Fill latency: `s_valid`=1 sampled with `cke`=1 at edge t gives `m_valid`=1 after edge t.
- Throughput: 1 item/cycle sustained while `m_ready`=1, including steady state at count = DEPTH−1.
- When full (count = DEPTH) with `m_ready`=1:
  - Edge t pops, and `cke` rises after edge t.
  - The next push happens at edge t+1.
  - At most one bubble per full→drain transition.
- Back-pressure:
  - `m_ready` low from edge t stops pops.
  - `cke` falls after the edge at which count reaches DEPTH.

## Configuration
- Macro: `SPU_DATA_DRAIN_LEVEL_EN`.
- Defined:
  - `level` = count.
  - `peak_level` register updates to max(`peak_level`, count_next) every cycle and clears only on reset.
- Undefined:
  - The `level` and `peak_level` ports remain in the port list, tied to constant 0.
  - No peak register is synthesized.

## Test plan
- Reset/start (DEPTH=4, DATA_BITS=8): hold `reset`=0 for 3 cycles, then release → `cke`=0, `m_valid`=0 during reset; `cke`=1 one edge after release.
- Streaming: `m_ready`=1, `s_valid`=1, `s_data` = 0x01..0x10 on consecutive cycles → `m_data` shows 0x01..0x10 in order, one per cycle, first `m_valid` one edge after first push, `level` ≤ 1.
- Fill and stall: `m_ready`=0, push 0xA0..0xA3 → `level`=4, `cke`=0 after the 4th push; hold `s_valid`=1 with 0xFF for 5 cycles → nothing accepted; then `m_ready`=1 → 0xA0..0xA3 out, followed by the held pipeline word.
- Pointer wrap and simultaneous events: keep count at 3 (DEPTH−1) with push and pop every cycle for 20 cycles, data 0x30..0x43 → in-order output, count constant at 3, `cke` stays 1, pointers wrap 5 times.
- Random back-pressure: 1000 items, `m_ready` random 50%, `s_valid` random 70% → scoreboard order match, push never observed at count=4, `peak_level`=4 with macro defined and 0 without.
- Mid-operation reset: assert `reset`=0 with count=3 → `m_valid`, `cke`, and `level` go to 0 immediately (asynchronously); after release, push 0x55 → output 0x55 only, no stale data.
